// File: rtl/sync_filter_pkg.sv
// Shared types and constants for the multi-channel input conditioner.
package sync_filter_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // True when an accepted transition to new_lvl should be reported under mode.
    function automatic logic edge_qualifies(input edge_mode_t mode, input logic new_lvl);
        case (mode)
            EDGE_RISE: return new_lvl;
            EDGE_FALL: return !new_lvl;
            EDGE_BOTH: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One conditioner channel: sync chain, stability filter, edge detect, sticky event.
module sync_filter_ch
    import sync_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_W      = 4,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              async_in,
    input  logic [FILT_W-1:0] filt_len,
    input  edge_mode_t        edge_mode,
    input  logic              evt_clr,
    output logic              level_out,
    output logic              edge_pulse,
    output logic              evt_sticky
);

    // Out-of-range depths are pulled into the supported window rather than
    // building a chain that is too short to be safe or needlessly long.
    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                            (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    logic              sync_s;
    logic [FILT_W-1:0] cnt_q;
    logic              level_q;
    logic              accept;
    logic              hit;

    assign sync_s = sync_q[STAGES-1];

    // >= lets a count already past a freshly lowered threshold complete at once.
    assign accept = (sync_s != level_q) && (cnt_q >= filt_len);
    assign hit    = accept && edge_qualifies(edge_mode, sync_s);

    // Synchroniser chain; reset loads the channel's idle level so release is quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= {sync_q[STAGES-2:0], async_in};
    end

    // Stability filter: level follows sync_s after filt_len+1 consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= RST_VAL;
            cnt_q   <= '0;
        end else if (sync_s == level_q) begin
            cnt_q   <= '0;
        end else if (accept) begin
            level_q <= sync_s;
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Edge pulse and sticky capture; a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_pulse <= 1'b0;
            evt_sticky <= 1'b0;
        end else begin
            edge_pulse <= hit;
            evt_sticky <= hit | (evt_sticky & ~evt_clr);
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/sync_filter_bank.sv
// NUM_CH independent input conditioners plus an any-event summary.
module sync_filter_bank
    import sync_filter_pkg::*;
#(
    parameter int                NUM_CH      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_W      = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     async_in,
    input  logic [FILT_W-1:0]     filt_len,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     evt_clr,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     edge_pulse,
    output logic [NUM_CH-1:0]     evt_sticky,
    output logic                  evt_any
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .RST_VAL     (RESET_VAL[i])
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .async_in   (async_in[i]),
            .filt_len   (filt_len),
            .edge_mode  (edge_mode_t'(edge_mode[2*i +: 2])),
            .evt_clr    (evt_clr[i]),
            .level_out  (level_out[i]),
            .edge_pulse (edge_pulse[i]),
            .evt_sticky (evt_sticky[i])
        );
    end

    // Driven only by sticky flops, so glitch-free for the interrupt controller.
    assign evt_any = |evt_sticky;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank: reset, bypass, glitch filter, edge modes,
// sticky race, threshold change and mid-count reset.
module tb_sync_filter_bank;

    localparam int             NUM_CH      = 8;
    localparam int             SYNC_STAGES = 2;
    localparam int             FILT_W      = 4;
    localparam logic [NUM_CH-1:0] RESET_VAL = 8'h0F;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_CH-1:0]     async_in;
    logic [FILT_W-1:0]     filt_len;
    logic [2*NUM_CH-1:0]   edge_mode;
    logic [NUM_CH-1:0]     evt_clr;
    logic [NUM_CH-1:0]     level_out;
    logic [NUM_CH-1:0]     edge_pulse;
    logic [NUM_CH-1:0]     evt_sticky;
    logic                  evt_any;

    int vecs;
    int errs;
    int pcnt [NUM_CH];

    sync_filter_bank #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W),
        .RESET_VAL   (RESET_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (async_in),
        .filt_len   (filt_len),
        .edge_mode  (edge_mode),
        .evt_clr    (evt_clr),
        .level_out  (level_out),
        .edge_pulse (edge_pulse),
        .evt_sticky (evt_sticky),
        .evt_any    (evt_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks; observe 1 time unit after each edge and tally pulses.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++)
                if (edge_pulse[c]) pcnt[c]++;
        end
    endtask

    task automatic clr_pcnt();
        for (int c = 0; c < NUM_CH; c++) pcnt[c] = 0;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        edge_mode[2*ch +: 2] = m;
    endtask

    task automatic clear_all_sticky();
        evt_clr = '1;
        tick(1);
        evt_clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; async_in = 8'h0F; filt_len = '0; edge_mode = '0; evt_clr = '0;
        clr_pcnt();
        tick(3);
        vecs++;
        if ({level_out, edge_pulse, evt_sticky, evt_any} !== {8'h0F, 8'h00, 8'h00, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: level=%h pulse=%h sticky=%h any=%b want 0f/00/00/0",
                     level_out, edge_pulse, evt_sticky, evt_any);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            vecs++;
            if ({level_out, edge_pulse, evt_any} !== {8'h0F, 8'h00, 1'b0}) begin
                errs++;
                $display("FAIL reset_release cyc %0d: level=%h pulse=%h any=%b want 0f/00/0",
                         k, level_out, edge_pulse, evt_any);
            end
        end
    endtask

    task automatic test_bypass();
        set_mode(4, 2'b01);
        async_in[4] = 1'b1;
        tick(2);
        vecs++;
        if (level_out[4] !== 1'b0) begin
            errs++; $display("FAIL bypass_early: level4=%b want 0", level_out[4]);
        end
        tick(1);
        vecs++;
        if ({level_out[4], edge_pulse, evt_sticky} !== {1'b1, 8'h10, 8'h10}) begin
            errs++;
            $display("FAIL bypass_edge: level4=%b pulse=%h sticky=%h want 1/10/10",
                     level_out[4], edge_pulse, evt_sticky);
        end
        tick(1);
        vecs++;
        if ({edge_pulse[4], evt_sticky[4], evt_any} !== 3'b011) begin
            errs++;
            $display("FAIL bypass_after: pulse4=%b sticky4=%b any=%b want 0/1/1",
                     edge_pulse[4], evt_sticky[4], evt_any);
        end
    endtask

    task automatic test_glitch();
        filt_len = 4'd3;
        set_mode(0, 2'b00);
        async_in[0] = 1'b0;
        tick(8);
        vecs++;
        if (level_out[0] !== 1'b0) begin
            errs++; $display("FAIL glitch_prep: level0=%b want 0", level_out[0]);
        end
        set_mode(0, 2'b11);
        clr_pcnt();
        // 3-clock pulse: one short of the 4 stable cycles needed.
        async_in[0] = 1'b1;
        tick(3);
        async_in[0] = 1'b0;
        tick(10);
        vecs++;
        if ({level_out[0], pcnt[0] == 0} !== 2'b01) begin
            errs++; $display("FAIL glitch_reject: level0=%b pulses=%0d want 0/0", level_out[0], pcnt[0]);
        end
        // 6-clock pulse: rise lands SYNC_STAGES+4 clocks after the drive.
        async_in[0] = 1'b1;
        tick(5);
        vecs++;
        if (level_out[0] !== 1'b0) begin
            errs++; $display("FAIL glitch_rise_early: level0=%b want 0", level_out[0]);
        end
        tick(1);
        vecs++;
        if ({level_out[0], edge_pulse[0]} !== 2'b11) begin
            errs++; $display("FAIL glitch_rise: level0=%b pulse0=%b want 1/1", level_out[0], edge_pulse[0]);
        end
        async_in[0] = 1'b0;
        tick(5);
        vecs++;
        if (level_out[0] !== 1'b1) begin
            errs++; $display("FAIL glitch_fall_early: level0=%b want 1", level_out[0]);
        end
        tick(1);
        vecs++;
        if ({level_out[0], edge_pulse[0]} !== 2'b01) begin
            errs++; $display("FAIL glitch_fall: level0=%b pulse0=%b want 0/1", level_out[0], edge_pulse[0]);
        end
        vecs++;
        if (pcnt[0] !== 2) begin
            errs++; $display("FAIL glitch_pulse_count: got %0d want 2", pcnt[0]);
        end
    endtask

    task automatic test_edge_modes();
        filt_len = '0;
        set_mode(1, 2'b00); set_mode(2, 2'b00); set_mode(3, 2'b00);
        async_in[3:1] = 3'b000;
        tick(5);
        clear_all_sticky();
        vecs++;
        if ({level_out[3:1], evt_sticky} !== {3'b000, 8'h00}) begin
            errs++; $display("FAIL modes_prep: level[3:1]=%b sticky=%h want 000/00", level_out[3:1], evt_sticky);
        end
        set_mode(1, 2'b01); set_mode(2, 2'b10); set_mode(3, 2'b00);
        clr_pcnt();
        async_in[3:1] = 3'b111;
        tick(5);
        vecs++;
        if ({level_out[3:1], pcnt[1] == 1, pcnt[2] == 0, pcnt[3] == 0} !== 6'b111_111) begin
            errs++;
            $display("FAIL modes_rise: level[3:1]=%b pulses %0d/%0d/%0d want 111 1/0/0",
                     level_out[3:1], pcnt[1], pcnt[2], pcnt[3]);
        end
        async_in[3:1] = 3'b000;
        tick(5);
        vecs++;
        if ({pcnt[1] == 1, pcnt[2] == 1, pcnt[3] == 0} !== 3'b111) begin
            errs++;
            $display("FAIL modes_fall: pulses %0d/%0d/%0d want 1/1/0", pcnt[1], pcnt[2], pcnt[3]);
        end
        vecs++;
        if (evt_sticky !== 8'b0000_0110) begin
            errs++; $display("FAIL modes_sticky: got %b want 00000110", evt_sticky);
        end
    endtask

    task automatic test_sticky_race();
        clear_all_sticky();
        vecs++;
        if (evt_any !== 1'b0) begin
            errs++; $display("FAIL race_prep: any=%b want 0", evt_any);
        end
        async_in[1] = 1'b1;
        tick(2);
        // Clear sampled on the same edge that raises edge_pulse[1].
        evt_clr[1] = 1'b1;
        tick(1);
        vecs++;
        if ({edge_pulse[1], evt_sticky[1]} !== 2'b11) begin
            errs++; $display("FAIL race_set_wins: pulse1=%b sticky1=%b want 1/1", edge_pulse[1], evt_sticky[1]);
        end
        tick(1);
        evt_clr[1] = 1'b0;
        vecs++;
        if ({evt_sticky[1], evt_any} !== 2'b00) begin
            errs++; $display("FAIL race_clear: sticky1=%b any=%b want 0/0", evt_sticky[1], evt_any);
        end
    endtask

    task automatic test_threshold();
        set_mode(5, 2'b01);
        filt_len = 4'd10;
        clr_pcnt();
        async_in[5] = 1'b1;
        // Two sync clocks then 7 counting cycles.
        tick(9);
        vecs++;
        if (level_out[5] !== 1'b0) begin
            errs++; $display("FAIL thresh_pending: level5=%b want 0", level_out[5]);
        end
        filt_len = 4'd2;
        tick(1);
        vecs++;
        if ({level_out[5], edge_pulse[5]} !== 2'b11) begin
            errs++; $display("FAIL thresh_lowered: level5=%b pulse5=%b want 1/1", level_out[5], edge_pulse[5]);
        end
        tick(1);
        vecs++;
        if ({edge_pulse[5], pcnt[5] == 1} !== 2'b01) begin
            errs++; $display("FAIL thresh_single: pulse5=%b pulses=%0d want 0/1", edge_pulse[5], pcnt[5]);
        end
    endtask

    task automatic test_reset_mid();
        set_mode(6, 2'b11);
        filt_len = 4'd8;
        async_in[6] = 1'b1;
        tick(6);
        vecs++;
        if ({level_out[6], evt_sticky[5]} !== 2'b01) begin
            errs++; $display("FAIL rstmid_prep: level6=%b sticky5=%b want 0/1", level_out[6], evt_sticky[5]);
        end
        rst_n = 1'b0;
        tick(1);
        vecs++;
        if ({level_out, edge_pulse, evt_sticky, evt_any} !== {RESET_VAL, 8'h00, 8'h00, 1'b0}) begin
            errs++;
            $display("FAIL rstmid_reset: level=%h pulse=%h sticky=%h any=%b want 0f/00/00/0",
                     level_out, edge_pulse, evt_sticky, evt_any);
        end
        rst_n = 1'b1;
        clr_pcnt();
        // Full resync plus a fresh 9-cycle count from zero.
        tick(10);
        vecs++;
        if ({level_out[6], pcnt[6] == 0} !== 2'b01) begin
            errs++; $display("FAIL rstmid_restart: level6=%b pulses=%0d want 0/0", level_out[6], pcnt[6]);
        end
        tick(1);
        vecs++;
        if ({level_out[6], edge_pulse[6], pcnt[6] == 1} !== 3'b111) begin
            errs++;
            $display("FAIL rstmid_accept: level6=%b pulse6=%b pulses=%0d want 1/1/1",
                     level_out[6], edge_pulse[6], pcnt[6]);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0; async_in = '0; filt_len = '0; edge_mode = '0; evt_clr = '0;
        test_reset();
        test_bypass();
        test_glitch();
        test_edge_modes();
        test_sticky_race();
        test_threshold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sync_filter_bank.md
Name: sync_filter_bank

Overview:
- Multi-channel input conditioner. Brings NUM_CH asynchronous level inputs into a single clock domain: pins, interrupt lines from foreign domains, and slow status bits.
- Per channel, in order: a SYNC_STAGES flop chain, a programmable stability (glitch/debounce) filter, and configurable edge detection with sticky event capture.
- Generalises the single-channel 2FF path with channel count, filtering, edge modes and event latching.
- Sits in ip/clk_rst. Feeds the interrupt controller and GPIO blocks.

Parameters:
- NUM_CH, 8, number of independent channels.
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- FILT_W, 4, filter counter width; max filter length 2^FILT_W-1.
- RESET_VAL, '0 (NUM_CH bits), per-channel reset value of the sync chain and level_out.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- async_in  in  NUM_CH  raw asynchronous inputs.
- filt_len  in  FILT_W  shared stability threshold; 0 = no filtering.
- edge_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- evt_clr  in  NUM_CH  per-channel sticky clear, level-sensitive.
- level_out  out  NUM_CH  filtered synchronous level.
- edge_pulse  out  NUM_CH  one-cycle pulse on a qualifying level_out transition.
- evt_sticky  out  NUM_CH  latched events.
- evt_any  out  1  OR of evt_sticky; combinational from registers.

Behaviour:
- Reset (rst_n low at posedge clk):
  - sync chain[i] and level_out[i] = RESET_VAL[i].
  - filter counters = 0.
  - edge_pulse = 0, evt_sticky = 0, evt_any = 0.
  - Reset release never produces an edge or event.
  - Reset mid-count discards the pending transition.
- Sync chain: async_in[i] shifts through SYNC_STAGES flops every cycle. Let s[i] be the last stage.
- Filter, per channel, each cycle:
  - If s == level_out: cnt <= 0.
  - Else if cnt >= filt_len: level_out <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A transition is accepted only after s differs from level_out for filt_len+1 consecutive cycles.
  - Any return to equality restarts the count.
- Latency from an async_in change to level_out: SYNC_STAGES + filt_len + 1 cycles, ±1 for sampling uncertainty.
- filt_len changes take effect immediately. Using >= guarantees a pending count already above a reduced threshold completes on the next cycle. cnt never exceeds 2^FILT_W-1.
- Edge detect: edge_pulse[i] is registered and is high in exactly the cycle level_out[i] shows its new value, if the mode qualifies:
  - rise: 0->1.
  - fall: 1->0.
  - both: either direction.
  - none: never.
- A mode change affects only transitions accepted after the change.
- Sticky:
  - evt_sticky[i] sets in the same cycle as edge_pulse[i].
  - evt_clr[i] clears it on the next clock.
  - Simultaneous set and clear: set wins, so the event is not lost.
  - Held evt_clr keeps it clear except on cycles with a new edge.
- Channels are fully independent. Simultaneous events on all channels are all captured.
- Minimum accepted pulse width is filt_len+1 clocks after synchronisation. Shorter pulses are filtered out with no partial state visible.

Decomposition:
- Package sync_filter_pkg holds:
  - typedef enum logic [1:0] edge_mode_t {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - Constants SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4.
- One sub-module, sync_filter_ch: a single channel containing the sync chain, filter counter, edge detect and sticky bit. Parameters are SYNC_STAGES, FILT_W and RST_VAL.
- The top generates NUM_CH instances, slices edge_mode, and reduces evt_any.
- The ASYNC_REG attribute goes on the sync chain flops only.

Test Plan:
- Reset and bypass:
  - Stimulus: RESET_VAL=8'h0F, async_in=8'h0F held through reset release.
  - Required: level_out=8'h0F, edge_pulse=0 and evt_any=0 for 20 cycles.
  - Stimulus: filt_len=0, toggle ch4 0->1 with mode rise.
  - Required: level_out[4]=1 exactly SYNC_STAGES+1 cycles later, one-cycle edge_pulse[4], evt_sticky[4]=1.
- Glitch rejection: filt_len=3, ch0 mode both, async_in[0] high for 3 clocks then low → level_out[0] stays 0, no pulse. High for 6 clocks → level_out[0]=1 at SYNC_STAGES+4 cycles, pulse, then falls back after the low period qualifies.
- Edge modes: ch1=rise, ch2=fall, ch3=none, each driven 0→1→0 with filt_len=0 → ch1 pulses once on the rise, ch2 once on the fall, ch3 never. evt_sticky=8'b0000_0110.
- Sticky race: assert evt_clr[1] in the same cycle as a new edge_pulse[1] → evt_sticky[1] remains 1. Assert evt_clr[1] alone next cycle → evt_sticky[1]=0, evt_any=0.
- Threshold change mid-count: filt_len=10, ch5 differs for 7 cycles, then filt_len set to 2 → level_out[5] updates on the next clock, one pulse.
- Reset mid-operation: ch6 pending count 4 of filt_len=8, rst_n low for one cycle → counter cleared, level_out[6]=RESET_VAL[6], evt_sticky cleared, no pulse generated by the reset.
